// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 8-digit common-anode hex scan driver; `define LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg7_scan_driver #(
  parameter int DIV_SIZE = 8192
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [31:0] NUMBER,
  input  logic [7:0]  AN_MASK,
  output logic [7:0]  AN,
  output logic [6:0]  SEG
);
  localparam int CW = $clog2(DIV_SIZE);
  logic [CW-1:0] div_cnt;
  logic [2:0]    idx;
  logic          tick;
  logic          blank;
  logic [3:0]    nib;
  logic [7:0]    an_nxt;
  logic [6:0]    seg_nxt;
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
    endcase
  endfunction
  always_comb begin
    tick = div_cnt == CW'(DIV_SIZE - 1);
    nib = NUMBER[{idx, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx != 3'd0) && ((NUMBER >> {idx, 2'b00}) == 32'd0);
`else
    blank = 1'b0;
`endif
    an_nxt = ~(8'b1 << idx) | AN_MASK | (blank ? 8'hFF : 8'h00);
    seg_nxt = an_nxt[idx] ? 7'h7F : hex7(nib);
  end
  always_ff @(posedge clk or negedge RESET)
    if (!RESET) begin
      div_cnt <= '0;
      idx <= 3'd0;
      AN <= 8'hFF;
      SEG <= 7'h7F;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + CW'(1);
      idx <= idx + 3'(tick);
      AN <= an_nxt;
      SEG <= seg_nxt;
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan order, decode, masking, latency and async reset.
module tb_seg7_scan_driver;
  logic        clk = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] NUMBER = 32'h0;
  logic [7:0]  AN_MASK = 8'h0;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(.DIV_SIZE(4)) dut (
    .clk(clk), .RESET(RESET), .NUMBER(NUMBER), .AN_MASK(AN_MASK), .AN(AN), .SEG(SEG)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] an_e, input logic [6:0] seg_e);
    checks += 2;
    if (AN !== an_e) begin
      errors++;
      $display("FAIL %s AN got %h want %h", name, AN, an_e);
    end
    if (SEG !== seg_e) begin
      errors++;
      $display("FAIL %s SEG got %h want %h", name, SEG, seg_e);
    end
  endtask

  task automatic realign(input logic [31:0] num, input logic [7:0] mask);
    @(negedge clk);
    RESET = 1'b0;
    NUMBER = num;
    AN_MASK = mask;
    @(negedge clk);
    RESET = 1'b1;
  endtask

  task automatic test_reset;
    NUMBER = 32'h01234567;
    AN_MASK = 8'h00;
    RESET = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hold", 8'hFF, 7'h7F);
    RESET = 1'b1;
    @(negedge clk);
    chk("first_out", 8'hFE, 7'h78);
    repeat (4) @(negedge clk);
    chk("second_digit", 8'hFD, 7'h02);
  endtask

  task automatic test_scan;
    logic [6:0] seg_tab [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
    logic [7:0] an_tab  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    realign(32'h89ABCDEF, 8'h00);
    for (int d = 0; d < 8; d++)
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk($sformatf("scan_d%0d_c%0d", d, c), an_tab[d], seg_tab[d]);
      end
    @(negedge clk);
    chk("scan_wrap", 8'hFE, 7'h0E);
  endtask

  task automatic test_mask;
    logic [7:0] an_tab [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    realign(32'hFFFFFFFF, 8'h0F);
    for (int d = 0; d < 8; d++) begin
      @(negedge clk);
      chk($sformatf("mask_d%0d", d), an_tab[d], d < 4 ? 7'h7F : 7'h0E);
      repeat (3) @(negedge clk);
    end
    AN_MASK = 8'hFF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("mask_all_%0d", c), 8'hFF, 7'h7F);
    end
  endtask

  task automatic test_update;
    realign(32'h0, 8'h00);
    @(negedge clk);
    chk("update_before", 8'hFE, 7'h40);
    NUMBER = 32'h00000001;
    @(negedge clk);
    chk("update_after", 8'hFE, 7'h79);
  endtask

  task automatic test_async_reset;
    realign(32'h01234567, 8'h00);
    repeat (22) @(negedge clk);
    chk("pre_reset_idx5", 8'hDF, 7'h24);
    #1 RESET = 1'b0;
    #1 chk("async_reset", 8'hFF, 7'h7F);
    @(negedge clk);
    RESET = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("restart_c%0d", c), 8'hFE, 7'h78);
    end
    @(negedge clk);
    chk("restart_next", 8'hFD, 7'h02);
  endtask

  task automatic test_leading_zero;
    logic [6:0] seg_tab [8] = '{7'h12, 7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    logic [7:0] an_tab  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`ifndef LEADING_ZERO_BLANK_EN
    seg_tab = '{7'h12, 7'h40, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    an_tab  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
`endif
    realign(32'h00000A05, 8'h00);
    for (int d = 0; d < 8; d++) begin
      @(negedge clk);
      chk($sformatf("lz_d%0d", d), an_tab[d], seg_tab[d]);
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_mask;
    test_update;
    test_async_reset;
    test_leading_zero;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for an 8-digit common-anode 7-segment display; shows a 32-bit value as 8 hex digits.
- Contains its own scan-rate divider, implemented as a clock enable on the single system clock (no derived clocks).
- Sits between the system's value register and the board AN/SEG pins.

Parameters:
- DIV_SIZE, 8192, clk cycles per digit slot; legal range >= 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- NUMBER  input  32  value to display; digit k shows NUMBER[4k+3:4k], digit 0 rightmost.
- AN_MASK  input  8  bit k = 1 blanks digit k.
- AN  output  8  active-low digit enables, registered.
- SEG  output  7  active-low segments, registered; SEG[6:0] = g,f,e,d,c,b,a.

Behaviour:
- Reset (RESET=0, async): div_cnt=0, idx=0, AN=8'hFF, SEG=7'h7F. Reset released mid-scan restarts at digit 0 with a full slot.
- Divider: div_cnt counts 0..DIV_SIZE-1, then wraps to 0. tick=1 for one clk when div_cnt==DIV_SIZE-1.
- Scan: on tick, idx increments 0..7 and wraps 7->0. Each digit is active for exactly DIV_SIZE clks; a full frame is 8*DIV_SIZE clks.
- Outputs are registered every clk from the current idx, NUMBER and AN_MASK. Latency is 1 clk, so NUMBER/AN_MASK changes appear on the next edge with no frame sync.
- AN = ~(8'b1 << idx) | AN_MASK. At most one AN bit is low.
- SEG when the digit is shown: active-low hex decode of nibble N = NUMBER[4*idx+:4].
- Decode table: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex, 7-bit).
- SEG when the current digit is masked: 7'h7F.
- AN_MASK=8'hFF: AN=8'hFF and SEG=7'h7F continuously. The scan still advances.
- The divider never stops; there is no enable input.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit k (k>=1) is blanked (AN bit 1, SEG 7'h7F) when NUMBER[31:4k] == 0.
  - Digit 0 is always shown, so NUMBER=0 displays a single "0".
  - The blanking is ORed with AN_MASK.
- Undefined: all 8 digits are shown, including leading zeros; no extra logic.

Test Plan:
- Hold RESET=0 for 3 clks -> AN=FF, SEG=7F. Release with DIV_SIZE=4, NUMBER=32'h01234567, AN_MASK=0 -> first registered output AN=FE, SEG=78 ('7'). After 4 clks AN=FD, SEG=02 ('6').
- NUMBER=32'h89ABCDEF, DIV_SIZE=4, run 32 clks -> AN sequence FE,FD,FB,F7,EF,DF,BF,7F; SEG sequence 0E,06,21,46,03,08,10,00. Then wraps to FE.
- AN_MASK=8'h0F, NUMBER=32'hFFFFFFFF -> digits 0-3: AN=FF, SEG=7F. Digits 4-7: one AN low, SEG=0E.
- Change NUMBER from 0 to 32'h00000001 while idx=0 -> SEG goes 40->79 on the next clk, AN unchanged.
- Assert RESET low mid-slot at idx=5 -> outputs go to FF/7F immediately without a clk edge. After release the scan restarts at digit 0, which lasts a full DIV_SIZE clks.
- With LEADING_ZERO_BLANK_EN, NUMBER=32'h00000A05 -> digits 0-2 shown (SEG 12, 40, 08); digits 3-7 AN=FF, SEG=7F.
